// File: rtl/card_ram_arbiter_if.sv
// Bus bundle between the War-game helper units (deal/store/draw), the card-RAM
// arbiter and the RAM controller. The slave modport is the arbiter's view.
// The master modport is the combined view of the requesters and the RAM controller.
interface card_ram_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int OP_W   = 3,
    parameter int ARG_W  = 10,
    parameter int DATA_W = 16
);
    // Requester side
    logic [N_REQ-1:0]       req;
    logic [N_REQ*OP_W-1:0]  req_op;
    logic [N_REQ*ARG_W-1:0] req_arg;
    logic [N_REQ-1:0]       gnt;
    logic [N_REQ-1:0]       done;
    logic [DATA_W-1:0]      rsp_data;
    logic                   rsp_err;

    // RAM controller side
    logic                   ram_load_op;
    logic [OP_W-1:0]        ram_op;
    logic                   ram_load_arg;
    logic [ARG_W-1:0]       ram_arg;
    logic                   ram_enable;
    logic                   ram_finished;
    logic [DATA_W-1:0]      ram_out;

    modport slave (
        input  req, req_op, req_arg, ram_finished, ram_out,
        output gnt, done, rsp_data, rsp_err,
               ram_load_op, ram_op, ram_load_arg, ram_arg, ram_enable
    );

    modport master (
        output req, req_op, req_arg, ram_finished, ram_out,
        input  gnt, done, rsp_data, rsp_err,
               ram_load_op, ram_op, ram_load_arg, ram_arg, ram_enable
    );
endinterface

// File: rtl/card_ram_arbiter.sv
// Round-robin arbiter sharing the single card-RAM controller between the deal,
// store and draw units. It picks one requester, then sequences the RAM command
// (load op, load arg, run) and returns the result with a one-cycle done pulse.
// A run that never finishes is aborted after TIMEOUT cycles and flagged as an error.
module card_ram_arbiter #(
    parameter int N_REQ   = 3,
    parameter int OP_W    = 3,
    parameter int ARG_W   = 10,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic clock,
    input  logic reset,
    card_ram_arbiter_if.slave bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    localparam logic [IDX_W:0]   NREQ_L    = (IDX_W+1)'(N_REQ);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_REQ - 1);
    localparam logic [7:0]       TIMEOUT_L = 8'(TIMEOUT);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_GRANT    = 3'd1;
    localparam logic [2:0] S_LOAD_OP  = 3'd2;
    localparam logic [2:0] S_LOAD_ARG = 3'd3;
    localparam logic [2:0] S_RUN      = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    logic [2:0]        state_reg, state_next;
    logic [IDX_W-1:0]  winner_reg;
    logic [IDX_W-1:0]  rr_reg;
    logic [OP_W-1:0]   op_reg;
    logic [ARG_W-1:0]  arg_reg;
    logic [7:0]        cnt_reg;
    logic [DATA_W-1:0] rsp_data_reg;
    logic              rsp_err_reg;

    // Per-requester views of the packed op/arg buses
    logic [OP_W-1:0]   op_arr  [N_REQ];
    logic [ARG_W-1:0]  arg_arr [N_REQ];

    // Round-robin search: rotate the request vector so the rr pointer sits at bit 0
    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic [IDX_W-1:0]   pick_off;
    logic [IDX_W:0]     pick_sum;
    logic [IDX_W:0]     pick_wrap;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_valid;

    logic gnt_active;
    logic run_finish;
    logic run_timeout;

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_req
            assign op_arr[gi]   = bus.req_op[gi*OP_W +: OP_W];
            assign arg_arr[gi]  = bus.req_arg[gi*ARG_W +: ARG_W];
            assign bus.gnt[gi]  = gnt_active && (winner_reg == IDX_W'(gi));
            assign bus.done[gi] = (state_reg == S_DONE) && (winner_reg == IDX_W'(gi));
        end
    endgenerate

    assign req_dbl = {bus.req, bus.req};
    assign req_rot = req_dbl[rr_reg +: N_REQ];

    // Lowest set bit of the rotated vector, mapped back to a requester index
    always_comb begin
        pick_valid = |req_rot;
        pick_off   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                pick_off = IDX_W'(k);
            end
        end
        pick_sum  = {1'b0, rr_reg} + {1'b0, pick_off};
        pick_wrap = pick_sum - NREQ_L;
        pick_idx  = (pick_sum >= NREQ_L) ? pick_wrap[IDX_W-1:0] : pick_sum[IDX_W-1:0];
    end

    // A finish pulse beats a timeout landing on the same cycle
    assign run_finish  = (state_reg == S_RUN) && bus.ram_finished;
    assign run_timeout = (state_reg == S_RUN) && !bus.ram_finished && (cnt_reg == TIMEOUT_L);

    // Next-state logic for the command sequencer
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:     if (pick_valid) state_next = S_GRANT;
            S_GRANT:    state_next = S_LOAD_OP;
            S_LOAD_OP:  state_next = S_LOAD_ARG;
            S_LOAD_ARG: state_next = S_RUN;
            S_RUN:      if (run_finish || run_timeout) state_next = S_DONE;
            S_DONE:     state_next = S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // State, latched request, run counter, response and round-robin pointer
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            winner_reg   <= '0;
            rr_reg       <= '0;
            op_reg       <= '0;
            arg_reg      <= '0;
            cnt_reg      <= '0;
            rsp_data_reg <= '0;
            rsp_err_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                S_IDLE: begin
                    if (pick_valid) begin
                        winner_reg <= pick_idx;
                        op_reg     <= op_arr[pick_idx];
                        arg_reg    <= arg_arr[pick_idx];
                    end
                end
                S_LOAD_ARG: begin
                    // Counter reads 1 in the first RUN cycle, so it equals the RUN cycle number
                    cnt_reg <= 8'd1;
                end
                S_RUN: begin
                    cnt_reg <= cnt_reg + 8'd1;
                    if (run_finish) begin
                        rsp_data_reg <= bus.ram_out;
                        rsp_err_reg  <= 1'b0;
                    end else if (run_timeout) begin
                        rsp_data_reg <= '0;
                        rsp_err_reg  <= 1'b1;
                    end
                end
                S_DONE: begin
                    rr_reg <= (winner_reg == LAST_IDX) ? '0 : winner_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign gnt_active       = (state_reg != S_IDLE);
    assign bus.ram_load_op  = (state_reg == S_LOAD_OP);
    assign bus.ram_load_arg = (state_reg == S_LOAD_ARG);
    assign bus.ram_enable   = (state_reg == S_RUN);
    assign bus.ram_op       = ((state_reg == S_LOAD_OP) || (state_reg == S_LOAD_ARG) ||
                               (state_reg == S_RUN)) ? op_reg : '0;
    assign bus.ram_arg      = ((state_reg == S_LOAD_ARG) || (state_reg == S_RUN)) ? arg_reg : '0;
    assign bus.rsp_data     = rsp_data_reg;
    assign bus.rsp_err      = rsp_err_reg && (state_reg == S_DONE);
endmodule

// File: tb/tb_card_ram_arbiter.sv
// Directed testbench for card_ram_arbiter: single op, round robin, timeout,
// finish/timeout tie, asynchronous reset mid-run and early request drop.
module tb_card_ram_arbiter;
    logic clock;
    logic reset;
    int   total;
    int   bad;

    card_ram_arbiter_if #(.N_REQ(3), .OP_W(3), .ARG_W(10), .DATA_W(16)) bus_if ();

    card_ram_arbiter #(
        .N_REQ(3), .OP_W(3), .ARG_W(10), .DATA_W(16), .TIMEOUT(255)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic step();
        @(negedge clock);
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    // Waits for any done pulse; reports cycles waited and RUN cycles seen
    task automatic wait_done(input int max_cyc, output int cycles, output int en_cycles,
                             output logic ok);
        cycles = 0;
        en_cycles = 0;
        ok = 1'b0;
        while (cycles < max_cyc && !ok) begin
            @(negedge clock);
            cycles++;
            if (bus_if.ram_enable) en_cycles++;
            if (bus_if.done != 3'b000) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        total++; if (bus_if.gnt !== 3'b000) begin bad++; $display("FAIL reset_gnt: got %b expected 000", bus_if.gnt); end
        total++; if (bus_if.done !== 3'b000) begin bad++; $display("FAIL reset_done: got %b expected 000", bus_if.done); end
        total++; if ({bus_if.ram_load_op, bus_if.ram_load_arg, bus_if.ram_enable} !== 3'b000) begin
            bad++; $display("FAIL reset_strobes: got %b expected 000", {bus_if.ram_load_op, bus_if.ram_load_arg, bus_if.ram_enable}); end
        total++; if ({bus_if.ram_op, bus_if.ram_arg} !== 13'd0) begin
            bad++; $display("FAIL reset_op_arg: got %h expected 0", {bus_if.ram_op, bus_if.ram_arg}); end
        total++; if ({bus_if.rsp_data, bus_if.rsp_err} !== 17'd0) begin
            bad++; $display("FAIL reset_rsp: got %h expected 0", {bus_if.rsp_data, bus_if.rsp_err}); end
        reset = 1'b0;
        step();
        total++; if (bus_if.gnt !== 3'b000) begin bad++; $display("FAIL reset_idle_gnt: got %b expected 000", bus_if.gnt); end
        $display("test_reset complete");
    endtask

    task automatic test_single();
        bus_if.req_op[2:0]  = 3'd1;
        bus_if.req_arg[9:0] = 10'd52;
        bus_if.req = 3'b001;
        step();
        total++; if (bus_if.gnt !== 3'b001) begin bad++; $display("FAIL single_gnt: got %b expected 001", bus_if.gnt); end
        total++; if (bus_if.ram_load_op !== 1'b0) begin bad++; $display("FAIL single_no_early_load: got %b expected 0", bus_if.ram_load_op); end
        step();
        total++; if (bus_if.ram_load_op !== 1'b1 || bus_if.ram_op !== 3'd1) begin
            bad++; $display("FAIL single_load_op: got strobe=%b op=%0d expected strobe=1 op=1", bus_if.ram_load_op, bus_if.ram_op); end
        step();
        total++; if (bus_if.ram_load_arg !== 1'b1 || bus_if.ram_arg !== 10'd52 || bus_if.ram_load_op !== 1'b0) begin
            bad++; $display("FAIL single_load_arg: got strobe=%b arg=%0d op_strobe=%b expected 1 52 0",
                            bus_if.ram_load_arg, bus_if.ram_arg, bus_if.ram_load_op); end
        step();
        total++; if (bus_if.ram_enable !== 1'b1 || bus_if.done !== 3'b000) begin
            bad++; $display("FAIL single_run: got enable=%b done=%b expected 1 000", bus_if.ram_enable, bus_if.done); end
        step();
        bus_if.ram_finished = 1'b1;
        bus_if.ram_out = 16'h0A0C;
        step();
        bus_if.ram_finished = 1'b0;
        total++; if (bus_if.done !== 3'b001) begin bad++; $display("FAIL single_done: got %b expected 001", bus_if.done); end
        total++; if (bus_if.rsp_data !== 16'h0A0C || bus_if.rsp_err !== 1'b0) begin
            bad++; $display("FAIL single_rsp: got data=%h err=%b expected 0a0c 0", bus_if.rsp_data, bus_if.rsp_err); end
        bus_if.req = 3'b000;
        step();
        total++; if (bus_if.done !== 3'b000 || bus_if.gnt !== 3'b000) begin
            bad++; $display("FAIL single_after: got done=%b gnt=%b expected 000 000", bus_if.done, bus_if.gnt); end
        $display("test_single complete: rsp_data=%h", bus_if.rsp_data);
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_order [4];
        int   cyc, en;
        logic ok;
        exp_order[0] = 3'b001; exp_order[1] = 3'b010; exp_order[2] = 3'b100; exp_order[3] = 3'b001;
        pulse_reset();
        bus_if.ram_finished = 1'b1;
        bus_if.ram_out = 16'h00AA;
        bus_if.req = 3'b111;
        for (int i = 0; i < 4; i++) begin
            wait_done(20, cyc, en, ok);
            total++; if (!ok) begin bad++; $display("FAIL rr_wait_%0d: got no done within 20 cycles expected done", i); end
            total++; if (bus_if.done !== exp_order[i] || bus_if.gnt !== exp_order[i]) begin
                bad++; $display("FAIL rr_order_%0d: got done=%b gnt=%b expected %b", i, bus_if.done, bus_if.gnt, exp_order[i]); end
            total++; if (cyc !== ((i == 0) ? 5 : 6)) begin
                bad++; $display("FAIL rr_latency_%0d: got %0d cycles expected %0d", i, cyc, (i == 0) ? 5 : 6); end
            $display("round robin op %0d: done=%b after %0d cycles", i, bus_if.done, cyc);
        end
        bus_if.req = 3'b000;
        bus_if.ram_finished = 1'b0;
        step();
    endtask

    task automatic test_timeout();
        int   cyc, en;
        logic ok;
        bus_if.req_op[8:6]   = 3'd5;
        bus_if.req_arg[29:20] = 10'h3FF;
        bus_if.ram_out = 16'hBEEF;
        bus_if.req = 3'b100;
        step();
        // Requester changes after IDLE exit must not reach the RAM command
        bus_if.req_op[8:6]   = 3'd0;
        bus_if.req_arg[29:20] = 10'h000;
        step();
        step();
        step();
        total++; if (bus_if.ram_enable !== 1'b1 || bus_if.ram_op !== 3'd5 || bus_if.ram_arg !== 10'h3FF) begin
            bad++; $display("FAIL timeout_latched: got en=%b op=%0d arg=%h expected 1 5 3ff",
                            bus_if.ram_enable, bus_if.ram_op, bus_if.ram_arg); end
        wait_done(300, cyc, en, ok);
        total++; if (!ok) begin bad++; $display("FAIL timeout_wait: got no done within 300 cycles expected done"); end
        total++; if (en + 1 !== 255) begin bad++; $display("FAIL timeout_enable_len: got %0d expected 255", en + 1); end
        total++; if (bus_if.done !== 3'b100) begin bad++; $display("FAIL timeout_done: got %b expected 100", bus_if.done); end
        total++; if (bus_if.rsp_err !== 1'b1 || bus_if.rsp_data !== 16'h0000) begin
            bad++; $display("FAIL timeout_rsp: got err=%b data=%h expected 1 0000", bus_if.rsp_err, bus_if.rsp_data); end
        bus_if.req = 3'b000;
        step();
        $display("test_timeout complete: enable cycles=%0d", en + 1);
    endtask

    task automatic test_tie();
        int   en;
        int   cyc;
        logic fired;
        logic seen;
        en = 0; cyc = 0; fired = 1'b0; seen = 1'b0;
        bus_if.ram_out = 16'h1234;
        bus_if.req = 3'b100;
        while (cyc < 300 && !seen) begin
            step();
            cyc++;
            if (fired) bus_if.ram_finished = 1'b0;
            if (bus_if.done != 3'b000) begin
                seen = 1'b1;
            end else begin
                if (bus_if.ram_enable) en++;
                if (en == 255 && !fired) begin
                    bus_if.ram_finished = 1'b1;
                    fired = 1'b1;
                end
            end
        end
        bus_if.ram_finished = 1'b0;
        total++; if (!seen) begin bad++; $display("FAIL tie_wait: got no done within 300 cycles expected done"); end
        total++; if (bus_if.done !== 3'b100) begin bad++; $display("FAIL tie_done: got %b expected 100", bus_if.done); end
        total++; if (bus_if.rsp_err !== 1'b0 || bus_if.rsp_data !== 16'h1234) begin
            bad++; $display("FAIL tie_rsp: got err=%b data=%h expected 0 1234", bus_if.rsp_err, bus_if.rsp_data); end
        bus_if.req = 3'b000;
        step();
        $display("test_tie complete: rsp_data=%h", bus_if.rsp_data);
    endtask

    task automatic test_async_reset();
        int   cyc, en, dones;
        logic ok;
        // Serve requester 0 so the rr pointer moves off zero
        bus_if.ram_finished = 1'b1;
        bus_if.ram_out = 16'h7777;
        bus_if.req = 3'b001;
        wait_done(20, cyc, en, ok);
        total++; if (!ok || bus_if.done !== 3'b001) begin bad++; $display("FAIL areset_pre_done: got %b expected 001", bus_if.done); end
        bus_if.req = 3'b000;
        bus_if.ram_finished = 1'b0;
        step();
        bus_if.req = 3'b100;
        cyc = 0;
        while (cyc < 10 && bus_if.ram_enable !== 1'b1) begin
            step();
            cyc++;
        end
        total++; if (bus_if.ram_enable !== 1'b1) begin bad++; $display("FAIL areset_reach_run: got enable=%b expected 1", bus_if.ram_enable); end
        #2 reset = 1'b1;
        #1;
        total++; if ({bus_if.gnt, bus_if.done, bus_if.ram_enable, bus_if.ram_load_op, bus_if.ram_load_arg} !== 9'd0) begin
            bad++; $display("FAIL areset_ctrl: got gnt=%b done=%b en=%b expected all 0", bus_if.gnt, bus_if.done, bus_if.ram_enable); end
        total++; if ({bus_if.ram_op, bus_if.ram_arg, bus_if.rsp_data, bus_if.rsp_err} !== 30'd0) begin
            bad++; $display("FAIL areset_data: got op=%0d arg=%h data=%h err=%b expected all 0",
                            bus_if.ram_op, bus_if.ram_arg, bus_if.rsp_data, bus_if.rsp_err); end
        bus_if.req = 3'b000;
        step();
        reset = 1'b0;
        dones = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus_if.done != 3'b000) dones++;
        end
        total++; if (dones !== 0) begin bad++; $display("FAIL areset_no_done: got %0d dones expected 0", dones); end
        // With rr back at 0 requester 0 wins over requester 2
        bus_if.ram_finished = 1'b1;
        bus_if.req = 3'b101;
        wait_done(20, cyc, en, ok);
        total++; if (!ok || bus_if.done !== 3'b001) begin bad++; $display("FAIL areset_rr: got %b expected 001", bus_if.done); end
        bus_if.req = 3'b000;
        step();
        bus_if.req = 3'b010;
        wait_done(20, cyc, en, ok);
        total++; if (!ok || bus_if.done !== 3'b010) begin bad++; $display("FAIL areset_next: got %b expected 010", bus_if.done); end
        bus_if.req = 3'b000;
        bus_if.ram_finished = 1'b0;
        step();
        $display("test_async_reset complete");
    endtask

    task automatic test_early_drop();
        bus_if.req_op[5:3]   = 3'd3;
        bus_if.req_arg[19:10] = 10'd7;
        bus_if.req = 3'b010;
        step();
        total++; if (bus_if.gnt !== 3'b010) begin bad++; $display("FAIL drop_gnt: got %b expected 010", bus_if.gnt); end
        bus_if.req = 3'b000;
        step();
        // Finish pulse outside RUN must be ignored
        bus_if.ram_finished = 1'b1;
        bus_if.ram_out = 16'hFFFF;
        step();
        bus_if.ram_finished = 1'b0;
        step();
        total++; if (bus_if.ram_enable !== 1'b1 || bus_if.done !== 3'b000) begin
            bad++; $display("FAIL drop_run: got en=%b done=%b expected 1 000", bus_if.ram_enable, bus_if.done); end
        bus_if.ram_finished = 1'b1;
        bus_if.ram_out = 16'h5555;
        step();
        bus_if.ram_finished = 1'b0;
        total++; if (bus_if.done !== 3'b010) begin bad++; $display("FAIL drop_done: got %b expected 010", bus_if.done); end
        total++; if (bus_if.rsp_data !== 16'h5555 || bus_if.rsp_err !== 1'b0) begin
            bad++; $display("FAIL drop_rsp: got data=%h err=%b expected 5555 0", bus_if.rsp_data, bus_if.rsp_err); end
        step();
        total++; if (bus_if.done !== 3'b000 || bus_if.gnt !== 3'b000) begin
            bad++; $display("FAIL drop_after: got done=%b gnt=%b expected 000 000", bus_if.done, bus_if.gnt); end
        $display("test_early_drop complete: rsp_data=%h", bus_if.rsp_data);
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b1;
        bus_if.req = 3'b000;
        bus_if.req_op = '0;
        bus_if.req_arg = '0;
        bus_if.ram_finished = 1'b0;
        bus_if.ram_out = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_timeout();
        test_tie();
        test_async_reset();
        test_early_drop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
